// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: add/logic/barrel-shift ops registered in one cycle,
// unsigned shift-add multiply over WIDTH cycles, valid/ready on both sides.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       main_sel,
  input  logic [1:0]       sub_sel,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH:0]     mul_sum;

  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             c_q, z_q, n_q, v_q, valid_q;

  logic accept, is_mul, load_single, start_mul, load_mul;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH:0]     add_sum;
  logic               add_v;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     shr_ext, asr_ext, shl_ext;
  logic [2*WIDTH-1:0] rol_ext;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_z, sc_n;

  assign in_ready = !rst && (state_q == IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (main_sel == 2'b11) && (sub_sel == 2'b00);

  // Arithmetic: every op is A + operand + cin so carry and overflow share one adder.
  always_comb begin
    add_b = '0;
    case (sub_sel)
      2'b00:   add_b = '0;
      2'b01:   add_b = B;
      2'b10:   add_b = ~B;
      default: add_b = '1;
    endcase
  end

  assign add_sum = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
  assign add_v   = (A[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);

  // Shifts carry one extra bit so the last bit shifted out falls out naturally (0 when s=0).
  assign shamt   = B[SHW-1:0];
  assign shr_ext = {A, 1'b0} >> shamt;
  assign asr_ext = $signed({A, 1'b0}) >>> shamt;
  assign shl_ext = {1'b0, A} << shamt;
  assign rol_ext = {A, A} << shamt;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (main_sel)
      2'b00: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = add_v;
      end
      2'b01: begin
        case (sub_sel)
          2'b00:   sc_res = A & B;
          2'b01:   sc_res = A | B;
          2'b10:   sc_res = A ^ B;
          default: sc_res = ~A;
        endcase
      end
      2'b10: begin
        case (sub_sel)
          2'b00: begin
            sc_res = shr_ext[WIDTH:1];
            sc_c   = shr_ext[0];
          end
          2'b01: begin
            sc_res = shl_ext[WIDTH-1:0];
            sc_c   = shl_ext[WIDTH];
          end
          2'b10: begin
            sc_res = asr_ext[WIDTH:1];
            sc_c   = asr_ext[0];
          end
          default: begin
            sc_res = rol_ext[2*WIDTH-1:WIDTH];
            sc_c   = (shamt != '0) && rol_ext[WIDTH];
          end
        endcase
      end
      default: begin
        sc_res = '0;
      end
    endcase
  end

  assign sc_z = (sc_res == '0);
  assign sc_n = sc_res[WIDTH-1];

  // Product register holds {partial sum, remaining multiplier bits}; one add and shift per cycle.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    load_single = 1'b0;
    start_mul   = 1'b0;
    load_mul    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            start_mul = 1'b1;
            state_d   = MUL;
          end else begin
            load_single = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q == CNT_LAST) begin
          load_mul = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (start_mul) begin
      cnt_q   <= '0;
      mcand_q <= A;
      prod_q  <= {{WIDTH{1'b0}}, B};
    end else if (state_q == MUL) begin
      cnt_q  <= cnt_q + SHW'(1);
      prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      res_hi_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      valid_q  <= 1'b0;
    end else if (load_single) begin
      res_q    <= sc_res;
      res_hi_q <= '0;
      c_q      <= sc_c;
      z_q      <= sc_z;
      n_q      <= sc_n;
      v_q      <= sc_v;
      valid_q  <= 1'b1;
    end else if (load_mul) begin
      res_q    <= prod_d[WIDTH-1:0];
      res_hi_q <= prod_d[2*WIDTH-1:WIDTH];
      c_q      <= |prod_d[2*WIDTH-1:WIDTH];
      z_q      <= (prod_d == '0);
      n_q      <= prod_d[2*WIDTH-1];
      v_q      <= 1'b0;
      valid_q  <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;
  assign out_valid = valid_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It keeps the same `main_sel`/`sub_sel`/`cin` operation encoding and adds four things: a configurable data width, registered results with status flags, barrel shifts by a variable amount, and a multi-cycle shift-add unsigned multiplier. It sits between an operand-issue stage and a writeback stage, and uses valid/ready handshakes on both sides.

## Interface

**Parameters**
- `WIDTH`, default 8: operand/result width; must be a power of two, at least 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `A` in `WIDTH`: operand A.
- `B` in `WIDTH`: operand B; `B[SHW-1:0]` is the shift amount.
- `main_sel` in 2: operation class.
- `sub_sel` in 2: operation within class.
- `cin` in 1: carry-in (arithmetic class only).
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block accepts operands this cycle.
- `result` out `WIDTH`: result, or product low half.
- `result_hi` out `WIDTH`: product high half; 0 for all non-multiply ops.
- `flag_c`, `flag_z`, `flag_n`, `flag_v` out 1 each: carry, zero, negative, overflow.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: downstream consumes the result.

## Operation

- **Accept:** an operation is accepted on a cycle with `in_valid && in_ready`. `A`, `B`, `main_sel`, `sub_sel` and `cin` are sampled on that edge.
- **Arithmetic, `main_sel=00`** (all add-based, `WIDTH+1`-bit sum, `flag_c` = bit `WIDTH`, `flag_v` = signed overflow):
  - `sub 00`: `A+cin`
  - `sub 01`: `A+B+cin`
  - `sub 10`: `A+~B+cin`
  - `sub 11`: `A+{WIDTH{1}}+cin` (decrement when `cin=0`, transfer A when `cin=1`)
- **Logic, `main_sel=01`:** `sub 00` AND, `01` OR, `10` XOR, `11` `~A`. Flags: `c=0`, `v=0`.
- **Shift, `main_sel=10`, amount `s=B[SHW-1:0]`:** `sub 00` logical right, `01` logical left, `10` arithmetic right, `11` rotate left.
  - `flag_c` = last bit shifted out; for rotate, `flag_c = result[0]`.
  - `flag_c=0` when `s=0`. `v=0`.
- **Multiply, `main_sel=11, sub 00`:** unsigned `A×B`, giving `{result_hi,result}`.
  - Shift-add, one partial product per cycle, `WIDTH` iterations.
  - Flags: `c = |result_hi`, `z` = both halves zero, `n = result_hi[WIDTH-1]`, `v=0`.
- **Reserved, `main_sel=11, sub 01/10/11`:** single-cycle; result 0, `result_hi` 0, `z=1`, other flags 0.
- **`flag_z` / `flag_n`:** for all non-multiply ops, `flag_z = (result==0)` and `flag_n = result[WIDTH-1]`.
- **FSM:**
  - `IDLE`: a single-cycle op is accepted, written to the output registers, and the FSM stays in `IDLE`; accepting a multiply goes to `MUL`.
  - `MUL`: an iteration counter runs 0..`WIDTH-1`. At count `WIDTH-1` the product is loaded into the outputs, `out_valid` is set, and the FSM returns to `IDLE`.
- `in_ready = !rst && state==IDLE && (!out_valid || out_ready)`. Back-to-back accept is allowed in the same cycle the prior result is consumed.
- **Output hold:** while `out_valid && !out_ready`, `result`, `result_hi`, flags and `out_valid` hold stable.
- `out_valid` clears on consumption unless a new result is loaded on the same edge.

## Timing

- **Reset (asynchronous):**
  - `out_valid=0`; `result`, `result_hi` and all flags = 0; FSM to `IDLE`; counter = 0.
  - `in_ready=0` while `rst` is high.
- **Single-cycle op latency:** `out_valid` rises on the edge that accepts the op, i.e. visible 1 cycle after the accept cycle.
- **Multiply latency:** `out_valid` visible `WIDTH+1` cycles after the accept cycle (9 for `WIDTH=8`). `in_ready=0` throughout `MUL`.
- **Sustained throughput:** 1 single-cycle op per clock while `out_ready=1`.
- **Reset during `MUL`:** the multiply is aborted, no result is produced, and the block is ready the first cycle after `rst` falls.
- **Illegal `cin`/`B`:** X values on `cin` or `B` with logic or shift ops must not propagate X into flags. Use only the bits each op needs.

## Test plan

All scenarios use `WIDTH=8`.

1. **Signed overflow.** `A=7F`, `B=01`, `main=00`, `sub=01`, `cin=0` → `result=80`, `c=0`, `v=1`, `n=1`, `z=0`; `out_valid` exactly 1 cycle after accept.
2. **Subtract to zero.** `A=03`, `B=03`, `main=00`, `sub=10`, `cin=1` → `result=00`, `z=1`, `c=1`, `v=0`. Then `sub=11`, `cin=0`, `A=00` → `result=FF`, `c=0`, `n=1`.
3. **Shifts, `A=81`:**
   - arithmetic right, `B=03` → `F0`, `c=0`
   - rotate left, `B=01` → `03`, `c=1`
   - logical left, `B=00` → `81`, `c=0`
4. **Multiply.** `A=FF`, `B=FF`, `main=11`, `sub=00` → `result_hi=FE`, `result=01`, `c=1`, `n=1`; `out_valid` 9 cycles after accept; `in_ready=0` for all 8 `MUL` cycles.
5. **Backpressure.** Hold `out_ready=0` for 3 cycles after a result → outputs stable and `in_ready=0`. Then `out_ready=1` with `in_valid=1` → the old result is consumed and the new op accepted on the same edge; the new result is visible next cycle.
6. **Reset mid-multiply.** Assert `rst` 4 cycles into a multiply → all outputs 0 immediately (asynchronous). After release, a logic AND `A=0F`, `B=3C` → `result=0C`, 1 cycle latency, no stale product.
